reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Generates the board's reset tree from the 40 MHz PLL clock and its `locked` flag, and sits directly downstream of the PLL wrapper. It holds the system in reset until `locked` has been stable for a programmable interval, then releases `sys_reset` (peripherals, video, bus) and, a few cycles later, `cpu_reset` (6502 core). It also debounces the user reset button, which resets only the CPU, and re-enters reset on any loss of lock.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the `locked` and `button_n` synchronizers (≥2).
- `HOLD_CYCLES`, 1024: cycles `locked` must stay high before `sys_reset` releases (≥1).
- `CPU_DELAY`, 16: cycles between `sys_reset` release and `cpu_reset` release (≥1).
- `DEBOUNCE_CYCLES`, 40000: consecutive stable cycles required to accept a button edge, 1 ms at 40 MHz (≥1).

Ports:
- `clock` input 1: 40 MHz PLL output; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high master reset.
- `locked` input 1: PLL lock flag, treated as asynchronous.
- `button_n` input 1: raw user reset button, active-low, asynchronous and bouncy.
- `sys_reset` output 1: active-high system reset, registered.
- `cpu_reset` output 1: active-high CPU reset, registered.
- `running` output 1: high only in state RUN.
- `lock_lost` output 1: sticky flag set on any lock loss after the first lock. Cleared only by `reset`.

## Operation
- **Reset values while `reset` = 1:**
  - State is WAIT_LOCK and all counters are 0.
  - `sys_reset` = 1, `cpu_reset` = 1, `running` = 0, `lock_lost` = 0.
  - The `locked` synchronizer clears to 0 and the `button_n` synchronizer sets to 1 (released).
  - The debounced button is "released".
- **Synchronizers:** `locked_s` and `button_s` are the last stage of each chain.
- **Debouncer:**
  - The counter clears whenever `button_s` equals the debounced value, and increments otherwise.
  - When it reaches `DEBOUNCE_CYCLES-1` while still different, the debounced value takes `button_s` on the next edge and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`, with no wrap.
- **State machine** (one shared counter `cnt`, width `$clog2(max(HOLD_CYCLES,CPU_DELAY)+1)`):
  - WAIT_LOCK: `sys_reset` = 1, `cpu_reset` = 1. When `locked_s` = 1, go to HOLD with `cnt` = 0.
  - HOLD: `cnt` increments each cycle. When `cnt` = `HOLD_CYCLES-1`, go to CPU_HOLD with `cnt` = 0 and `sys_reset` ← 0.
  - CPU_HOLD: `sys_reset` = 0, `cpu_reset` = 1, and `cnt` increments. When `cnt` = `CPU_DELAY-1`, go to RUN and `cpu_reset` ← 0.
  - RUN: both resets are 0 and `running` = 1.
  - BUTTON: `sys_reset` = 0, `cpu_reset` = 1. When the debounced button releases, go to CPU_HOLD with `cnt` = 0.
- **Lock loss:** `locked_s` = 0 in HOLD, CPU_HOLD, RUN or BUTTON sends the state to WAIT_LOCK and reasserts both resets on the same edge. In every state except HOLD it also sets `lock_lost`; in HOLD the count simply restarts and `lock_lost` is not set.
- **Button press** (debounced value goes pressed) in CPU_HOLD or RUN sends the state to BUTTON.
  - A press in WAIT_LOCK or HOLD is ignored; the CPU is already in reset.
- **Priority** when events coincide on one edge: `reset` > lock loss > button > counter expiry.
- **Reset mid-operation:** asserting `reset` in any state forces the reset values immediately, without waiting for a clock edge.

## Timing
- Edge numbering: edge 1 is the first rising edge after `reset` falls, with `locked` already high.
  - `locked_s` = 1 after edge `SYNC_STAGES`.
  - HOLD is entered at edge `SYNC_STAGES+1`.
  - `sys_reset` falls after edge `SYNC_STAGES+1+HOLD_CYCLES`; defaults give 1027.
  - `cpu_reset` falls `CPU_DELAY` edges later; defaults give 1043.
- Lock loss: both resets rise `SYNC_STAGES+1` edges after `locked` falls.
- Button press: `cpu_reset` rises `SYNC_STAGES+DEBOUNCE_CYCLES+1` edges after a clean `button_n` fall.
  - A bounce shorter than `DEBOUNCE_CYCLES` cycles has no effect.
- Button release: `cpu_reset` falls `SYNC_STAGES+DEBOUNCE_CYCLES+1+CPU_DELAY` edges after a clean `button_n` rise.
- All outputs are registered; no output is combinational from an input.

## Test plan
Parameters for the bench: `SYNC_STAGES`=2, `HOLD_CYCLES`=8, `CPU_DELAY`=4, `DEBOUNCE_CYCLES`=5.
- **Power-up:** `locked` high, `reset` released → `sys_reset` falls after edge 11, `cpu_reset` after edge 15, `running`=1 from edge 15, `lock_lost`=0.
- **Late or glitchy lock:** `locked` high for 5 cycles, low for 1, then high → the HOLD count restarts, `sys_reset` is still 1 at edge 12, and `lock_lost`=0.
- **Lock loss in RUN:** drop `locked` → both resets are 1 three edges later and `lock_lost`=1. Re-raise `locked` → resets release with the same 11/15 spacing, and `lock_lost` stays 1.
- **Button:**
  - A 3-cycle low pulse on `button_n` in RUN → no change.
  - An 8-cycle low on `button_n` → `cpu_reset` rises 8 edges after the fall while `sys_reset` stays 0. After release, `cpu_reset` falls 12 edges after the rise.
- **Async reset mid-HOLD:** pulse `reset` between edges → all outputs reach reset values before the next edge, and the sequence restarts from edge 1.
- **Lock loss during BUTTON:** drop `locked` while in BUTTON → state goes to WAIT_LOCK, `sys_reset`=1, `lock_lost`=1, and the pending button release is ignored.

Source files
------------

// File: rtl/reset_sequencer.sv
// Board reset tree: waits for a stable PLL lock, releases sys_reset and then cpu_reset,
// debounces the user button into a CPU-only reset, and falls back to reset on lock loss.
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 1024,
  parameter int CPU_DELAY       = 16,
  parameter int DEBOUNCE_CYCLES = 40000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  input  logic       button_n,
  output logic       sys_reset,
  output logic       cpu_reset,
  output logic       running,
  output logic       lock_lost,
  output logic [2:0] state
);

  localparam int MAX_COUNT = (HOLD_CYCLES > CPU_DELAY) ? HOLD_CYCLES : CPU_DELAY;
  localparam int CW        = $clog2(MAX_COUNT + 1);
  localparam int DW        = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_DELAY - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    CPU_HOLD  = 3'd2,
    RUN       = 3'd3,
    BUTTON    = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lost_q, lost_d;
  logic sys_reset_d, cpu_reset_d, running_d;

  // ---------------------------------------------------------------------------
  // Synchronizers: locked clears to 0, button_n sets to 1 (released)
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] locked_sync;
  logic [SYNC_STAGES-1:0] button_sync;
  logic locked_s;
  logic button_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      locked_sync <= '0;
      button_sync <= '1;
    end else begin
      locked_sync <= {locked_sync[SYNC_STAGES-2:0], locked};
      button_sync <= {button_sync[SYNC_STAGES-2:0], button_n};
    end
  end

  assign locked_s = locked_sync[SYNC_STAGES-1];
  assign button_s = button_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debouncer: deb is the accepted level (1 = released)
  // ---------------------------------------------------------------------------
  logic [DW-1:0] deb_cnt;
  logic deb;
  logic deb_prev;
  logic press;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_cnt  <= '0;
      deb      <= 1'b1;
      deb_prev <= 1'b1;
    end else begin
      deb_prev <= deb;
      if (button_s == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb     <= button_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // One-cycle pulse on the edge after the debounced level goes pressed, so a
  // button held through power-up never counts as a fresh press later on.
  assign press = deb_prev & ~deb;

  // ---------------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      lost_q    <= 1'b0;
      sys_reset <= 1'b1;
      cpu_reset <= 1'b1;
      running   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lost_q    <= lost_d;
      sys_reset <= sys_reset_d;
      cpu_reset <= cpu_reset_d;
      running   <= running_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; priority is lock loss > button > counter expiry
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        // A lock drop here is a late or glitchy lock, not a loss.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = CPU_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CPU_HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          lost_d  = 1'b1;
        end else if (press) begin
          state_d = BUTTON;
          cnt_d   = '0;
        end else if (cnt_q == CPU_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          lost_d  = 1'b1;
        end else if (press) begin
          state_d = BUTTON;
          cnt_d   = '0;
        end
      end
      BUTTON: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          lost_d  = 1'b1;
        end else if (deb) begin
          state_d = CPU_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so outputs change on the same edge
  // ---------------------------------------------------------------------------
  always_comb begin
    sys_reset_d = 1'b1;
    cpu_reset_d = 1'b1;
    running_d   = 1'b0;
    case (state_d)
      WAIT_LOCK, HOLD: begin
        sys_reset_d = 1'b1;
        cpu_reset_d = 1'b1;
      end
      CPU_HOLD, BUTTON: begin
        sys_reset_d = 1'b0;
        cpu_reset_d = 1'b1;
      end
      RUN: begin
        sys_reset_d = 1'b0;
        cpu_reset_d = 1'b0;
        running_d   = 1'b1;
      end
      default: begin
        sys_reset_d = 1'b1;
        cpu_reset_d = 1'b1;
      end
    endcase
  end

  assign lock_lost = lost_q;
  assign state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short counts (HOLD 8, CPU 4, debounce 5).
module tb_reset_sequencer;

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_CPU    = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_BUTTON = 3'd4;

  logic       clock;
  logic       reset;
  logic       locked;
  logic       button_n;
  logic       sys_reset;
  logic       cpu_reset;
  logic       running;
  logic       lock_lost;
  logic [2:0] state;

  int vectors;
  int miscompares;

  reset_sequencer #(
    .SYNC_STAGES    (2),
    .HOLD_CYCLES    (8),
    .CPU_DELAY      (4),
    .DEBOUNCE_CYCLES(5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .locked   (locked),
    .button_n (button_n),
    .sys_reset(sys_reset),
    .cpu_reset(cpu_reset),
    .running  (running),
    .lock_lost(lock_lost),
    .state    (state)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // driver tasks
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // outputs packed as {sys_reset, cpu_reset, running, lock_lost}
  task automatic check_outs(input string tag, input logic [3:0] expected);
    check(tag, {4'b0, sys_reset, cpu_reset, running, lock_lost}, {4'b0, expected});
  endtask

  task automatic check_state(input string tag, input logic [2:0] expected);
    check(tag, {5'b0, state}, {5'b0, expected});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    locked      = 1'b1;
    button_n    = 1'b1;

    // reset values
    #12;
    check_outs("reset_outs", 4'b1100);
    check_state("reset_state", S_WAIT);

    // power-up: edge 1 is the first posedge after reset falls
    @(negedge clock);
    reset = 1'b0;
    wait_edges(2);
    check_state("pu_e2_wait", S_WAIT);
    wait_edges(1);
    check_state("pu_e3_hold", S_HOLD);
    wait_edges(7);
    check_outs("pu_e10", 4'b1100);
    wait_edges(1);
    check_outs("pu_e11", 4'b0100);
    check_state("pu_e11_state", S_CPU);
    wait_edges(3);
    check_outs("pu_e14", 4'b0100);
    wait_edges(1);
    check_outs("pu_e15", 4'b0010);
    check_state("pu_e15_state", S_RUN);

    // 3-cycle bounce: no effect
    button_n = 1'b0;
    wait_edges(3);
    button_n = 1'b1;
    wait_edges(10);
    check_outs("bounce_outs", 4'b0010);
    check_state("bounce_state", S_RUN);

    // 8-cycle press: cpu_reset rises 8 edges after the fall
    button_n = 1'b0;
    wait_edges(7);
    check_outs("press_e7", 4'b0010);
    wait_edges(1);
    check_outs("press_e8", 4'b0100);
    check_state("press_e8_state", S_BUTTON);
    button_n = 1'b1;
    wait_edges(11);
    check_outs("release_e11", 4'b0100);
    check_state("release_e11_state", S_CPU);
    wait_edges(1);
    check_outs("release_e12", 4'b0010);

    // lock loss in RUN
    locked = 1'b0;
    wait_edges(2);
    check_outs("loss_e2", 4'b0010);
    wait_edges(1);
    check_outs("loss_e3", 4'b1101);
    check_state("loss_e3_state", S_WAIT);

    // relock: same 11/15 spacing, lock_lost sticky
    locked = 1'b1;
    wait_edges(10);
    check_outs("relock_e10", 4'b1101);
    wait_edges(1);
    check_outs("relock_e11", 4'b0101);
    wait_edges(3);
    check_outs("relock_e14", 4'b0101);
    wait_edges(1);
    check_outs("relock_e15", 4'b0011);

    // lock loss during BUTTON
    button_n = 1'b0;
    wait_edges(8);
    check_state("btn2_state", S_BUTTON);
    check_outs("btn2_outs", 4'b0101);
    locked = 1'b0;
    wait_edges(3);
    check_state("btn_loss_state", S_WAIT);
    check_outs("btn_loss_outs", 4'b1101);
    button_n = 1'b1;
    wait_edges(12);
    check_state("btn_loss_release_state", S_WAIT);
    check_outs("btn_loss_release_outs", 4'b1101);

    // async reset mid-HOLD
    locked = 1'b1;
    wait_edges(5);
    check_state("mid_hold_state", S_HOLD);
    #2;
    reset = 1'b1;
    #1;
    check_outs("async_reset_outs", 4'b1100);
    check_state("async_reset_state", S_WAIT);
    reset = 1'b0;
    wait_edges(10);
    check_outs("restart_e10", 4'b1100);
    wait_edges(1);
    check_outs("restart_e11", 4'b0100);
    wait_edges(4);
    check_outs("restart_e15", 4'b0010);

    // late / glitchy lock: high 5, low 1, high
    reset = 1'b1;
    #2;
    reset = 1'b0;
    wait_edges(5);
    locked = 1'b0;
    wait_edges(1);
    locked = 1'b1;
    wait_edges(2);
    check_state("glitch_e8_state", S_WAIT);
    check_outs("glitch_e8_outs", 4'b1100);
    wait_edges(4);
    check_state("glitch_e12_state", S_HOLD);
    check_outs("glitch_e12_outs", 4'b1100);
    wait_edges(4);
    check_outs("glitch_e16", 4'b1100);
    wait_edges(1);
    check_outs("glitch_e17", 4'b0100);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
